// File: rtl/led_bar_arbiter.sv
// Purpose : round-robin owner of the LED bar among NREQ pattern sources, with a minimum dwell per owner.
// Latency : 1 cycle from req/pattern to grant/led/busy; owner handover takes a single edge.
// Backpr. : none; a source holds req until granted, and non-owner requests are not stored during dwell.
//
// Ports:
//   clk, rstn        system clock, asynchronous active-low reset
//   req[NREQ]        level request per source
//   pattern          source i drives bits [i*LED_W +: LED_W]
//   grant[NREQ]      one-hot current owner, zero when idle (registered)
//   led[LED_W]       bar drive: owner pattern or IDLE_PATTERN (registered)
//   busy             high while a grant is held (registered)
module led_bar_arbiter #(
    parameter int               NREQ         = 4,
    parameter int               LED_W        = 7,
    parameter int               HOLD         = 12000000,
    parameter logic [LED_W-1:0] IDLE_PATTERN = 7'h7F
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LED_W-1:0] pattern,
    output logic [NREQ-1:0]       grant,
    output logic [LED_W-1:0]      led,
    output logic                  busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] RELOAD   = CW'(HOLD - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last;
    logic [CW-1:0]   cnt;

    // Per-source view of the flat pattern bus.
    logic [LED_W-1:0] pat_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pat
            assign pat_arr[gi] = pattern[gi*LED_W +: LED_W];
        end
    endgenerate

    // Candidates for the next owner. While owned, the current owner is
    // masked out so the pick always names somebody else.
    logic [NREQ-1:0] cand;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   scan_idx;

    always_comb begin
        cand = (state == ST_OWNED) ? (req & ~grant) : req;
    end

    // Scan last+1, last+2, ... modulo NREQ; first hit wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IW'((int'(last) + k) % NREQ);
            if (!pick_vld && cand[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    logic own_req;
    logic take_new;

    always_comb begin
        own_req  = req[owner];
        // A new owner is taken when idle, when the owner lets go, or when
        // the dwell has expired; only ever if somebody else is waiting.
        take_new = pick_vld &&
                   ((state == ST_IDLE) || !own_req || (cnt == '0));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            owner <= '0;
            last  <= LAST_RST;
            cnt   <= '0;
            grant <= '0;
            led   <= IDLE_PATTERN;
            busy  <= 1'b0;
        end else begin
            if (take_new) begin
                // Covers first grant, release handover and preemption alike;
                // led follows the new owner on the same edge so no idle
                // pattern appears between owners.
                state <= ST_OWNED;
                owner <= pick_idx;
                last  <= pick_idx;
                cnt   <= RELOAD;
                grant <= NREQ'(1) << pick_idx;
                led   <= pat_arr[pick_idx];
                busy  <= 1'b1;
            end else if (state == ST_OWNED && own_req) begin
                // Keep owner; live pattern changes pass straight through.
                led <= pat_arr[owner];
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end
            end else begin
                // Idle, or owner released with nobody waiting.
                state <= ST_IDLE;
                grant <= '0;
                led   <= IDLE_PATTERN;
                busy  <= 1'b0;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_bar_arbiter.sv
// Purpose : directed self-checking bench for led_bar_arbiter (NREQ=4, HOLD=4, idle 7'h7F).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : n/a.
module tb_led_bar_arbiter;

    localparam int NREQ  = 4;
    localparam int LED_W = 7;
    localparam int HOLD  = 4;

    logic                  clk;
    logic                  rstn;
    logic [NREQ-1:0]       req;
    logic [NREQ*LED_W-1:0] pattern;
    logic [NREQ-1:0]       grant;
    logic [LED_W-1:0]      led;
    logic                  busy;

    int n_chk;
    int n_pass;

    led_bar_arbiter #(
        .NREQ        (NREQ),
        .LED_W       (LED_W),
        .HOLD        (HOLD),
        .IDLE_PATTERN(7'h7F)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .req    (req),
        .pattern(pattern),
        .grant  (grant),
        .led    (led),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pat(input int i, input logic [LED_W-1:0] v);
        pattern[i*LED_W +: LED_W] = v;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        #3;
        rstn = 1'b1;
    endtask

    logic [3:0] rr_seq [5];

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rstn    = 1'b0;
        req     = '0;
        pattern = '0;
        set_pat(0, 7'h01);
        set_pat(1, 7'h02);
        set_pat(2, 7'h15);
        set_pat(3, 7'h08);

        // 1. reset then idle
        #12;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_led",   32'(led),   32'h7F);
        rstn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_grant", 32'(grant), 32'h0);
            chk("idle_led",   32'(led),   32'h7F);
        end

        // 2. single requester, live pattern, release
        req = 4'b0100;
        step();
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_led",   32'(led),   32'h15);
        chk("single_busy",  32'(busy),  32'h1);
        set_pat(2, 7'h2A);
        step();
        chk("live_pat_led", 32'(led), 32'h2A);
        req = 4'b0000;
        step();
        chk("release_led",   32'(led),   32'h7F);
        chk("release_grant", 32'(grant), 32'h0);
        chk("release_busy",  32'(busy),  32'h0);

        // 3. round robin from a fresh reset so source 0 leads
        pulse_reset();
        set_pat(0, 7'h11);
        set_pat(1, 7'h22);
        set_pat(2, 7'h33);
        set_pat(3, 7'h44);
        rr_seq[0] = 4'b0001;
        rr_seq[1] = 4'b0010;
        rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000;
        rr_seq[4] = 4'b0001;
        req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < HOLD; c++) begin
                step();
                chk("rr_grant", 32'(grant), 32'(rr_seq[o]));
            end
        end
        chk("rr_led_src0", 32'(led), 32'h11);
        req = 4'b0000;
        step();
        chk("rr_idle", 32'(grant), 32'h0);

        // 4. dwell protection: src1 owns, src3 arrives one cycle later
        req = 4'b0010;
        step();
        chk("dwell_grant0", 32'(grant), 32'h2);
        req = 4'b1010;
        for (int c = 1; c < HOLD; c++) begin
            step();
            chk("dwell_hold", 32'(grant), 32'h2);
            chk("dwell_led",  32'(led),   32'h22);
        end
        step();
        chk("dwell_preempt", 32'(grant), 32'h8);
        chk("dwell_led3",    32'(led),   32'h44);
        req = 4'b0000;
        step();
        chk("dwell_idle", 32'(grant), 32'h0);

        // 5. release handover: src0 owns, src2 pending, src0 drops mid-dwell
        req = 4'b0001;
        step();
        chk("hand_grant0", 32'(grant), 32'h1);
        req = 4'b0101;
        step();
        chk("hand_keep0", 32'(grant), 32'h1);
        chk("hand_led0",  32'(led),   32'h11);
        req = 4'b0100;
        step();
        chk("hand_grant2", 32'(grant), 32'h4);
        chk("hand_led2",   32'(led),   32'h33);
        chk("hand_busy",   32'(busy),  32'h1);

        // 6. reset while src3 owns
        req = 4'b1000;
        step();
        chk("pre_rst_grant3", 32'(grant), 32'h8);
        rstn = 1'b0;
        #1;
        chk("async_rst_grant", 32'(grant), 32'h0);
        chk("async_rst_led",   32'(led),   32'h7F);
        chk("async_rst_busy",  32'(busy),  32'h0);
        req = 4'b1001;
        #2;
        rstn = 1'b1;
        step();
        chk("post_rst_grant0", 32'(grant), 32'h1);
        chk("post_rst_led0",   32'(led),   32'h11);
        for (int c = 1; c < HOLD; c++) begin
            step();
        end
        step();
        chk("post_rst_grant3", 32'(grant), 32'h8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
